// File: rtl/synth_pkg.sv
// synth_pkg: shared widths, FSM states and voice record for the voice allocator.
package synth_pkg;
  localparam int NOTE_W = 7;
  localparam int VEL_W = 7;
  localparam int SYS_CLOCK_FREQ = 50000000;
  localparam int VOICE_DIV_W = $clog2(SYS_CLOCK_FREQ) + 1;
  localparam int VOICE_AGE_W = 4;
  typedef enum logic [1:0] {IDLE, SELECT, COMMIT} va_state_t;
  typedef struct packed {
    logic [NOTE_W-1:0]      note;
    logic [VEL_W-1:0]       vel;
    logic [VOICE_DIV_W-1:0] div;
    logic [VOICE_AGE_W-1:0] age;
    logic                   gate;
    logic                   held;
  } voice_t;
endpackage

// File: rtl/voice_select.sv
// voice_select: combinational finder for the target voice (note match, free slot, or oldest).
module voice_select import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W = 4,
  localparam int IDX_W = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0] active_i,
  input  logic [NOTE_W-1:0]     note_i [NUM_VOICES],
  input  logic [AGE_W-1:0]      age_i [NUM_VOICES],
  input  logic                  req_on_i,
  input  logic [NOTE_W-1:0]     req_note_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  found_o,
  output logic                  is_steal_o
);
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic match_found, free_found;
  always_comb begin
    match_idx = '0;
    free_idx = '0;
    old_idx = '0;
    match_found = 1'b0;
    free_found = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_i[i] && note_i[i] == req_note_i) begin
        match_found = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!active_i[i]) begin
        free_found = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    // strict compare keeps the lowest index on age ties
    for (int i = 1; i < NUM_VOICES; i++)
      if (age_i[i] > age_i[old_idx]) old_idx = IDX_W'(i);
  end
  assign found_o = req_on_i || match_found;
  assign is_steal_o = req_on_i && !match_found && !free_found;
  assign idx_o = match_found ? match_idx : !req_on_i ? '0 : free_found ? free_idx : old_idx;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/off requests onto NUM_VOICES tone voices, stealing the oldest when full.
// Define VOICE_SUSTAIN_EN to add the sustain_in pedal port and per-voice held bits.
module voice_allocator import synth_pkg::*; #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_W = 27,
  parameter int AGE_W = 4
) (
  input  logic                        clock,
  input  logic                        clr_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_on,
  input  logic [NOTE_W-1:0]           req_note,
  input  logic [VEL_W-1:0]            req_vel,
  input  logic [DIV_W-1:0]            req_div,
  input  logic                        panic,
`ifdef VOICE_SUSTAIN_EN
  input  logic                        sustain_in,
`endif
  output logic [NUM_VOICES*DIV_W-1:0] voice_div,
  output logic [NUM_VOICES*VEL_W-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0]       voice_restart,
  output logic                        steal,
  output logic                        err
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  va_state_t state_q, state_d;
  logic up_q;
  logic rq_on_q, rq_on_d;
  logic [NOTE_W-1:0] rq_note_q, rq_note_d;
  logic [VEL_W-1:0] rq_vel_q, rq_vel_d;
  logic [DIV_W-1:0] rq_div_q, rq_div_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d, sel_idx;
  logic sel_found_q, sel_found_d, sel_found;
  logic sel_steal_q, sel_steal_d, sel_steal;
  logic [NOTE_W-1:0] note_q [NUM_VOICES], note_d [NUM_VOICES];
  logic [VEL_W-1:0] vel_q [NUM_VOICES], vel_d [NUM_VOICES];
  logic [DIV_W-1:0] div_q [NUM_VOICES], div_d [NUM_VOICES];
  logic [AGE_W-1:0] age_q [NUM_VOICES], age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d, restart_q, restart_d;
  logic steal_q, steal_d, err_q, err_d;
`ifdef VOICE_SUSTAIN_EN
  logic [NUM_VOICES-1:0] held_q, held_d;
  logic sus_q;
`endif

  voice_select #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W)) u_sel (
    .active_i(gate_q), .note_i(note_q), .age_i(age_q), .req_on_i(rq_on_q),
    .req_note_i(rq_note_q), .idx_o(sel_idx), .found_o(sel_found), .is_steal_o(sel_steal)
  );

  assign req_ready = up_q && state_q == IDLE && !panic;

  always_comb begin
    state_d = state_q;
    rq_on_d = rq_on_q;
    rq_note_d = rq_note_q;
    rq_vel_d = rq_vel_q;
    rq_div_d = rq_div_q;
    sel_idx_d = sel_idx_q;
    sel_found_d = sel_found_q;
    sel_steal_d = sel_steal_q;
    note_d = note_q;
    vel_d = vel_q;
    div_d = div_q;
    age_d = age_q;
    gate_d = gate_q;
    restart_d = '0;
    steal_d = 1'b0;
    err_d = 1'b0;
`ifdef VOICE_SUSTAIN_EN
    held_d = held_q;
    // pedal release lands before any same-cycle commit
    if (sus_q && !sustain_in)
      for (int i = 0; i < NUM_VOICES; i++)
        if (held_d[i]) begin
          gate_d[i] = 1'b0;
          held_d[i] = 1'b0;
          age_d[i] = '0;
        end
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        rq_on_d = req_on;
        rq_note_d = req_note;
        rq_vel_d = req_vel;
        rq_div_d = req_div;
        state_d = SELECT;
      end
      SELECT: begin
        sel_idx_d = sel_idx;
        sel_found_d = sel_found;
        sel_steal_d = sel_steal;
        state_d = COMMIT;
      end
      default: begin
        state_d = IDLE;
        if (rq_on_q && rq_div_q == '0) err_d = 1'b1;
        else if (rq_on_q) begin
          for (int i = 0; i < NUM_VOICES; i++)
            if (gate_d[i]) age_d[i] = (age_d[i] == AGE_MAX) ? age_d[i] : age_d[i] + 1'b1;
          note_d[sel_idx_q] = rq_note_q;
          vel_d[sel_idx_q] = rq_vel_q;
          div_d[sel_idx_q] = rq_div_q;
          gate_d[sel_idx_q] = 1'b1;
          age_d[sel_idx_q] = '0;
          restart_d[sel_idx_q] = 1'b1;
          steal_d = sel_steal_q;
`ifdef VOICE_SUSTAIN_EN
          held_d[sel_idx_q] = 1'b0;
`endif
        end else if (sel_found_q) begin
`ifdef VOICE_SUSTAIN_EN
          if (sustain_in) held_d[sel_idx_q] = 1'b1;
          else begin
            gate_d[sel_idx_q] = 1'b0;
            age_d[sel_idx_q] = '0;
          end
`else
          gate_d[sel_idx_q] = 1'b0;
          age_d[sel_idx_q] = '0;
`endif
        end
      end
    endcase
    if (panic) begin
      state_d = IDLE;
      gate_d = '0;
      age_d = '{default: '0};
      restart_d = '0;
      steal_d = 1'b0;
      err_d = 1'b0;
`ifdef VOICE_SUSTAIN_EN
      held_d = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      up_q <= 1'b0;
      rq_on_q <= 1'b0;
      rq_note_q <= '0;
      rq_vel_q <= '0;
      rq_div_q <= '0;
      sel_idx_q <= '0;
      sel_found_q <= 1'b0;
      sel_steal_q <= 1'b0;
      note_q <= '{default: '0};
      vel_q <= '{default: '0};
      div_q <= '{default: '0};
      age_q <= '{default: '0};
      gate_q <= '0;
      restart_q <= '0;
      steal_q <= 1'b0;
      err_q <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
      held_q <= '0;
      sus_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      up_q <= 1'b1;
      rq_on_q <= rq_on_d;
      rq_note_q <= rq_note_d;
      rq_vel_q <= rq_vel_d;
      rq_div_q <= rq_div_d;
      sel_idx_q <= sel_idx_d;
      sel_found_q <= sel_found_d;
      sel_steal_q <= sel_steal_d;
      note_q <= note_d;
      vel_q <= vel_d;
      div_q <= div_d;
      age_q <= age_d;
      gate_q <= gate_d;
      restart_q <= restart_d;
      steal_q <= steal_d;
      err_q <= err_d;
`ifdef VOICE_SUSTAIN_EN
      held_q <= held_d;
      sus_q <= sustain_in;
`endif
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_div[g*DIV_W +: DIV_W] = div_q[g];
    assign voice_vel[g*VEL_W +: VEL_W] = vel_q[g];
  end
  assign voice_gate = gate_q;
  assign voice_restart = restart_q;
  assign steal = steal_q;
  assign err = err_q;
endmodule
